// File: rtl/booth_mul_param_if.sv
// booth_mul_param_if: start/ready/done operand and result bus for booth_mul_param
interface booth_mul_param_if #(parameter int W = 5);
  logic start;
  logic sgn;
  logic [W-1:0] inbus;
  logic ready;
  logic done;
  logic [2*W-1:0] result;
  modport master(output start, sgn, inbus, input ready, done, result);
  modport slave(input start, sgn, inbus, output ready, done, result);
endinterface

// File: rtl/booth_mul_param.sv
// booth_mul_param: sequential Booth multiplier, signed/unsigned per op; BOOTH_RADIX4_EN selects radix-4 steps
module booth_mul_param #(parameter int W = 5) (
  input logic clk,
  input logic rst,
  booth_mul_param_if.slave bus
);
`ifdef BOOTH_RADIX4_EN
  localparam int YW = (W + 2) / 2 * 2;
  localparam int AW = YW + 2;
  localparam int ST = 2;
  localparam int NS = (W + 1) / 2;
  localparam int NU = (W + 2) / 2;
  localparam int SSH = YW - (W + 1) / 2 * 2;
`else
  localparam int YW = W + 1;
  localparam int AW = W + 2;
  localparam int ST = 1;
  localparam int NS = W;
  localparam int NU = W + 1;
  localparam int SSH = 1;
`endif
  localparam int CW = $clog2(W + 2);
  localparam int PW = AW + YW + 1;
  typedef enum logic [1:0] {IDLE, LOAD_Y, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d;
  logic qm_q, qm_d;
  logic [W-1:0] x_q, x_d;
  logic [AW-1:0] a_q, a_d;
  logic [YW-1:0] y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] res_q, res_d;
  logic [AW-1:0] xe, addend;
  logic [PW-1:0] p;
  always_comb begin
    xe = {{(AW-W){mode_q & x_q[W-1]}}, x_q};
`ifdef BOOTH_RADIX4_EN
    addend = ({y_q[1:0], qm_q} == 3'b001 || {y_q[1:0], qm_q} == 3'b010) ? xe :
             ({y_q[1:0], qm_q} == 3'b011) ? xe << 1 :
             ({y_q[1:0], qm_q} == 3'b100) ? -(xe << 1) :
             ({y_q[1:0], qm_q} == 3'b101 || {y_q[1:0], qm_q} == 3'b110) ? -xe : '0;
`else
    addend = ({y_q[0], qm_q} == 2'b01) ? xe : ({y_q[0], qm_q} == 2'b10) ? -xe : '0;
`endif
    p = $signed({a_q + addend, y_q, qm_q}) >>> ST;
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    x_d = x_q;
    a_d = a_q;
    y_d = y_q;
    qm_d = qm_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d = bus.inbus;
          mode_d = bus.sgn;
          state_d = LOAD_Y;
        end
      end
      LOAD_Y: begin
        y_d = {{(YW-W){mode_q & bus.inbus[W-1]}}, bus.inbus};
        a_d = '0;
        qm_d = 1'b0;
        cnt_d = mode_q ? CW'(NS) : CW'(NU);
        state_d = CALC;
      end
      CALC: begin
        {a_d, y_d, qm_d} = p;
        cnt_d = cnt_q - CW'(1);
        // only the multiplier bits actually consumed sit below A; drop the unconsumed tail
        if (cnt_q == CW'(1)) begin
          res_d = (2*W)'(p[PW-1:1] >> (mode_q ? SSH : 0));
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      x_q <= '0;
      a_q <= '0;
      y_q <= '0;
      qm_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      x_q <= x_d;
      a_q <= a_d;
      y_q <= y_d;
      qm_q <= qm_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = res_q;
endmodule

// File: tb/tb_booth_mul_param.sv
// tb_booth_mul_param: directed vector table plus reset and busy-start sequences on W=5 and W=8 instances
module tb_booth_mul_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  booth_mul_param_if #(5) i5();
  booth_mul_param_if #(8) i8();
  booth_mul_param #(.W(5)) d5(.clk(clk), .rst(rst), .bus(i5));
  booth_mul_param #(.W(8)) d8(.clk(clk), .rst(rst), .bus(i8));
  typedef struct {
    bit w8;
    bit s;
    logic [7:0] x;
    logic [7:0] y;
    logic [15:0] r;
  } vec_t;
  vec_t v[13];
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  function automatic void drive(bit w8, bit st, bit s, logic [7:0] d);
    if (w8) begin
      i8.start = st;
      i8.sgn = s;
      i8.inbus = d;
    end else begin
      i5.start = st;
      i5.sgn = s;
      i5.inbus = d[4:0];
    end
  endfunction
  function automatic logic rdy(bit w8);
    return w8 ? i8.ready : i5.ready;
  endfunction
  function automatic logic dn(bit w8);
    return w8 ? i8.done : i5.done;
  endfunction
  function automatic logic [15:0] res(bit w8);
    return w8 ? i8.result : {6'd0, i5.result};
  endfunction
  function automatic int exp_lat(bit w8, bit s);
    int w;
    w = w8 ? 8 : 5;
`ifdef BOOTH_RADIX4_EN
    return 1 + (s ? (w + 1) / 2 : (w + 2) / 2);
`else
    return 1 + (s ? w : w + 1);
`endif
  endfunction
  task automatic run_op(input bit w8, input bit s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] r, input bit poke, input string nm);
    int e;
    int pulses;
    bit seen;
    @(posedge clk); #1;
    drive(w8, 1'b1, s, x);
    @(posedge clk); #1;
    drive(w8, 1'b0, ~s, y);
    chk({nm, " ready_busy"}, 32'(rdy(w8)), 32'd0);
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      @(posedge clk); #1;
      e++;
      drive(w8, poke && e == 3, ~s, 8'h07);
      if (dn(w8)) seen = 1'b1;
    end
    chk({nm, " latency"}, 32'(e), 32'(exp_lat(w8, s)));
    chk({nm, " result"}, 32'(res(w8)), 32'(r));
    @(posedge clk); #1;
    chk({nm, " done_low"}, 32'(dn(w8)), 32'd0);
    chk({nm, " ready_back"}, 32'(rdy(w8)), 32'd1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dn(w8)) pulses++;
    end
    chk({nm, " extra_done"}, 32'(pulses), 32'd0);
    chk({nm, " result_hold"}, 32'(res(w8)), 32'(r));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int pulses;
    logic [15:0] last5;
    v[0] = '{0, 1, 8'h0D, 8'h15, 16'h0371};
    v[1] = '{0, 0, 8'h1F, 8'h1F, 16'h03C1};
    v[2] = '{0, 1, 8'h10, 8'h10, 16'h0100};
    v[3] = '{0, 1, 8'h00, 8'h1B, 16'h0000};
    v[4] = '{0, 1, 8'h10, 8'h0F, 16'h0310};
    v[5] = '{0, 0, 8'h05, 8'h06, 16'h001E};
    v[6] = '{0, 1, 8'h03, 8'h04, 16'h000C};
    v[7] = '{0, 1, 8'h1F, 8'h1F, 16'h0001};
    v[8] = '{1, 1, 8'h80, 8'h7F, 16'hC080};
    v[9] = '{1, 0, 8'hFF, 8'hFF, 16'hFE01};
    v[10] = '{1, 1, 8'h80, 8'h80, 16'h4000};
    v[11] = '{1, 1, 8'hFF, 8'h01, 16'hFFFF};
    v[12] = '{1, 0, 8'hC8, 8'h03, 16'h0258};
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready5", 32'(i5.ready), 32'd1);
    chk("rst done5", 32'(i5.done), 32'd0);
    chk("rst result5", 32'(i5.result), 32'd0);
    chk("rst ready8", 32'(i8.ready), 32'd1);
    chk("rst result8", 32'(i8.result), 32'd0);
    rst = 1'b0;
    last5 = 16'h0;
    for (int i = 0; i < 13; i++) begin
      run_op(v[i].w8, v[i].s, v[i].x, v[i].y, v[i].r, 1'b0, $sformatf("vec%0d", i));
      if (!v[i].w8) last5 = v[i].r;
    end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 8'd9);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 8'd9);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst held", 32'(i5.result), 32'(last5));
    chk("midrst busy", 32'(i5.ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst ready", 32'(i5.ready), 32'd1);
    chk("midrst done", 32'(i5.done), 32'd0);
    chk("midrst result", 32'(i5.result), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i5.done) pulses++;
    end
    chk("midrst no_done", 32'(pulses), 32'd0);
    drive(0, 1'b1, 1'b1, 8'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 8'd4);
    chk("rst_start ready", 32'(i5.ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_start idle", 32'(i5.ready), 32'd1);
    run_op(0, 1'b1, 8'd3, 8'd4, 16'h000C, 1'b0, "after_rst");
    run_op(0, 1'b1, 8'h0D, 8'h15, 16'h0371, 1'b1, "busy_start");
    run_op(1, 1'b1, 8'h80, 8'h7F, 16'hC080, 1'b1, "busy_start8");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
